// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file and its scoreboard.
//   reg_idx_t     : architectural register index
//   NUM_ARCH_REGS : number of architectural integer registers
//   REG_ZERO      : hard-wired zero register index (never tracked)
package regfile_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam int       NUM_ARCH_REGS = 32;
    localparam reg_idx_t REG_ZERO      = 5'd0;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for a single architectural register.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous, active-low reset
//   clear   : drop all pending writes (pipeline flush)
//   inc     : one more write to this register was issued
//   dec     : a writeback to this register occurred
//   count   : current number of outstanding writes
//   nonzero : count != 0
import regfile_pkg::*;

module sb_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 nonzero
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic dec_eff;

    // A writeback with nothing pending is ignored here; the top flags it.
    assign dec_eff = dec && nonzero;
    assign nonzero = (count != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !dec_eff && count != CNT_MAX) begin
            count <= count + 1'b1;
        end else if (dec_eff && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: tracks outstanding writes per integer register and
// holds stage-1 issue off while a source is pending (RAW) or a destination
// already has the maximum number of writes in flight (WAW bound).
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN -- a source with exactly one
// pending write that is written back this very cycle counts as free, so issue
// can fire in the writeback cycle (register file forwards the stage-5 result).
// Ports:
//   clk, reset                     : clock, synchronous active-low reset
//   issue_valid/rs1/rs2/use_rs1/use_rs2/rd/wr_rd : stage-1 instruction
//   issue_ready                    : instruction accepted this cycle
//   wb_valid, wb_rd                : stage-5 writeback
//   flush                          : clear all pending state
//   busy_mask                      : per-register pending flag
//   underflow_err                  : sticky, writeback with nothing pending
//   stall_cycles                   : cycles with issue_valid && !issue_ready
import regfile_pkg::*;

module regfile_scoreboard #(
    parameter int NUM_REGS        = NUM_ARCH_REGS,
    parameter int CNT_WIDTH       = 2,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  reg_idx_t                   issue_rs1,
    input  reg_idx_t                   issue_rs2,
    input  logic                       issue_use_rs1,
    input  logic                       issue_use_rs2,
    input  reg_idx_t                   issue_rd,
    input  logic                       issue_wr_rd,
    output logic                       issue_ready,
    input  logic                       wb_valid,
    input  reg_idx_t                   wb_rd,
    input  logic                       flush,
    output logic [NUM_REGS-1:0]        busy_mask,
    output logic                       underflow_err,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
    logic                 issue_fire;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 raw_hit;
    logic                 waw_full;

    // x0 is never tracked.
    assign cnt[0]       = '0;
    assign busy_mask[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        sb_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .clear  (flush),
            .inc    (issue_fire && issue_wr_rd && issue_rd == reg_idx_t'(i)),
            .dec    (wb_valid && wb_rd == reg_idx_t'(i)),
            .count  (cnt[i]),
            .nonzero(busy_mask[i])
        );
    end

    always_comb begin
        rs1_busy = issue_use_rs1 && cnt[issue_rs1] != '0;
        rs2_busy = issue_use_rs2 && cnt[issue_rs2] != '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        // The last pending write lands this cycle; the read port gets it forwarded.
        if (wb_valid && wb_rd == issue_rs1 && cnt[issue_rs1] == CNT_ONE) rs1_busy = 1'b0;
        if (wb_valid && wb_rd == issue_rs2 && cnt[issue_rs2] == CNT_ONE) rs2_busy = 1'b0;
`endif
        raw_hit  = rs1_busy || rs2_busy;
        waw_full = issue_wr_rd && issue_rd != REG_ZERO && cnt[issue_rd] == CNT_MAX;
    end

    // Hazards are judged on current counts, so a same-cycle writeback frees
    // its register for the following cycle only (unless bypass is enabled).
    assign issue_ready = reset && !raw_hit && !waw_full && !flush;
    assign issue_fire  = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            underflow_err <= 1'b0;
        end else if (wb_valid && wb_rd != REG_ZERO && cnt[wb_rd] == '0) begin
            underflow_err <= 1'b1;
        end
    end

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (issue_valid && !issue_ready) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
import regfile_pkg::*;

module tb_regfile_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    reg_idx_t    issue_rs1, issue_rs2, issue_rd;
    logic        issue_use_rs1, issue_use_rs2, issue_wr_rd;
    logic        issue_ready;
    logic        wb_valid;
    reg_idx_t    wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic        underflow_err;
    logic [31:0] stall_cycles;

    regfile_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_use_rs1(issue_use_rs1),
        .issue_use_rs2(issue_use_rs2),
        .issue_rd     (issue_rd),
        .issue_wr_rd  (issue_wr_rd),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy_mask    (busy_mask),
        .underflow_err(underflow_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: plain pending-write counts per register.
    int          m_cnt [32];
    bit          m_uf;
    logic [31:0] m_stall;
    bit          m_valid = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit src_busy(input int r);
        bit b;
        b = (m_cnt[r] != 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_valid && int'(wb_rd) == r && m_cnt[r] == 1) b = 0;
`endif
        return b;
    endfunction

    function automatic bit model_ready();
        bit raw, waw;
        if (!reset || flush) return 0;
        raw = (issue_use_rs1 && src_busy(int'(issue_rs1))) ||
              (issue_use_rs2 && src_busy(int'(issue_rs2)));
        waw = issue_wr_rd && issue_rd != 0 && m_cnt[issue_rd] == MAXC;
        return !raw && !waw;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        for (int i = 1; i < 32; i++) m[i] = (m_cnt[i] != 0);
        return m;
    endfunction

    task automatic model_update();
        bit rdy, dec_ok, fire;
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_uf    = 0;
            m_stall = '0;
            m_valid = 1;
            return;
        end
        rdy  = model_ready();
        fire = issue_valid && rdy;
        if (issue_valid && !rdy) m_stall = m_stall + 1;
        if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0) m_uf = 1;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
            dec_ok = wb_valid && wb_rd != 0 && m_cnt[wb_rd] > 0;
            if (fire && issue_wr_rd && issue_rd != 0) m_cnt[issue_rd]++;
            if (dec_ok) m_cnt[wb_rd]--;
        end
    endtask

    // Sample at the falling edge: model vs DUT on every meaningful cycle.
    task automatic sample();
        @(negedge clk);
        if (m_valid && reset) begin
            check("issue_ready", 64'(issue_ready), 64'(model_ready()));
            check("busy_mask", 64'(busy_mask), 64'(model_mask()));
            check("underflow_err", 64'(underflow_err), 64'(m_uf));
            check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr_rd = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic do_issue_wr(input int rd);
        idle(); issue_valid = 1; issue_wr_rd = 1; issue_rd = reg_idx_t'(rd);
    endtask

    task automatic do_wb(input int rd);
        idle(); wb_valid = 1; wb_rd = reg_idx_t'(rd);
    endtask

    initial begin
        idle();
        // Reset while issue_valid and flush are asserted
        reset = 0; issue_valid = 1; flush = 1;
        sample(); advance();
        reset = 1; idle();
        sample();
        check("rst_busy", 64'(busy_mask), 64'h0);
        check("rst_ready", 64'(issue_ready), 64'h1);
        check("rst_stall", 64'(stall_cycles), 64'h0);
        check("rst_uf", 64'(underflow_err), 64'h0);
        advance();

        // RAW on r5
        do_issue_wr(5); sample(); check("raw_issue5", 64'(issue_ready), 64'h1); advance();
        idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 5;
        sample(); check("raw_c1_ready", 64'(issue_ready), 64'h0);
        check("raw_c1_busy5", 64'(busy_mask[5]), 64'h1); advance();
        sample(); check("raw_c2_stall", 64'(stall_cycles), 64'h1); advance();
        wb_valid = 1; wb_rd = 5;
        sample();
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("raw_c3_ready", 64'(issue_ready), 64'h1);
`else
        check("raw_c3_ready", 64'(issue_ready), 64'h0);
`endif
        advance();
        wb_valid = 0;
        sample(); check("raw_c4_ready", 64'(issue_ready), 64'h1);
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("raw_c4_stall", 64'(stall_cycles), 64'h2);
`else
        check("raw_c4_stall", 64'(stall_cycles), 64'h3);
`endif
        advance();

        // WAW bound on r7
        for (int k = 0; k < 3; k++) begin
            do_issue_wr(7); sample(); advance();
        end
        do_issue_wr(7); sample(); check("waw_full", 64'(issue_ready), 64'h0); advance();
        wb_valid = 1; wb_rd = 7;
        sample(); check("waw_wb_cycle", 64'(issue_ready), 64'h0); advance();
        wb_valid = 0;
        sample(); check("waw_after_wb", 64'(issue_ready), 64'h1); advance();
        for (int k = 0; k < 3; k++) begin
            do_wb(7); sample(); advance();
        end
        idle(); sample(); check("waw_drained", 64'(busy_mask[7]), 64'h0); advance();

        // Simultaneous issue and writeback on r9
        do_issue_wr(9); sample(); advance();
        do_issue_wr(9); wb_valid = 1; wb_rd = 9; sample(); advance();
        idle(); sample(); check("inc_dec_busy9", 64'(busy_mask[9]), 64'h1); advance();
        do_wb(9); sample(); advance();

        // x0 traffic has no effect, then underflow on r12
        do_issue_wr(0); wb_valid = 1; wb_rd = 0; sample(); advance();
        idle(); sample();
        check("x0_busy", 64'(busy_mask[0]), 64'h0);
        check("x0_no_err", 64'(underflow_err), 64'h0); advance();
        do_wb(12); sample(); advance();
        idle(); sample();
        check("uf_set", 64'(underflow_err), 64'h1);
        check("uf_busy", 64'(busy_mask), 64'h0); advance();

        // Flush with r3, r4, r5 pending
        do_issue_wr(3); sample(); advance();
        do_issue_wr(4); sample(); advance();
        do_issue_wr(5); sample(); advance();
        idle(); issue_valid = 1; flush = 1;
        sample(); check("flush_ready", 64'(issue_ready), 64'h0);
        check("flush_pending", 64'(busy_mask), 64'h38); advance();
        idle(); sample(); check("flush_cleared", 64'(busy_mask), 64'h0); advance();

        // Randomized traffic on a small register window to create hazards
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 299) != 0);
            issue_valid   = ($urandom_range(0, 99) < 70);
            issue_rs1     = reg_idx_t'($urandom_range(0, 7));
            issue_rs2     = reg_idx_t'($urandom_range(0, 7));
            issue_rd      = reg_idx_t'($urandom_range(0, 7));
            issue_use_rs1 = $urandom_range(0, 1) != 0;
            issue_use_rs2 = $urandom_range(0, 1) != 0;
            issue_wr_rd   = ($urandom_range(0, 99) < 80);
            wb_valid      = ($urandom_range(0, 99) < 45);
            wb_rd         = reg_idx_t'($urandom_range(0, 7));
            flush         = ($urandom_range(0, 79) == 0);
            sample(); advance();
        end
        reset = 1; idle(); sample(); advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
